block_matmul_engine: RTL

- Parametrised DIM x DIM matrix-multiply block for the NeuroCore datapath. Generalises the fixed 10-element block multiplier to a configurable dimension and element width.
- Three phases: stream in A and B element pairs, compute C = A x B on one internal MAC, then stream C out through a valid/ready handshake.
- Supports signed and unsigned operand modes.

---
 rtl/neurocore_pkg.sv | 24 ++
 rtl/block_matmul_engine_mac.sv | 50 +++++
 rtl/block_matmul_engine.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/neurocore_pkg.sv
// Shared definitions for the NeuroCore datapath blocks: FSM state encoding,
// the default operand width and the accumulator sizing rule.
package neurocore_pkg;

   localparam int DEF_BIT_W = 8;

   localparam logic [1:0] IDLE_ENC    = 2'd0;
   localparam logic [1:0] LOAD_ENC    = 2'd1;
   localparam logic [1:0] COMPUTE_ENC = 2'd2;
   localparam logic [1:0] STORE_ENC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = IDLE_ENC,
      ST_LOAD    = LOAD_ENC,
      ST_COMPUTE = COMPUTE_ENC,
      ST_STORE   = STORE_ENC
   } state_t;

   // A dot product of dim full-width products cannot exceed this width.
   function automatic int acc_width(input int bit_w, input int dim);
      return 2 * bit_w + $clog2(dim);
   endfunction

endpackage

// File: rtl/block_matmul_engine_mac.sv
// Single multiply-accumulate unit. acc presents the running sum including the
// current product, so the owner can capture a finished dot product directly.
module mac_unit #(
   parameter int BIT_W = 8,
   parameter int ACC_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIT_W-1:0] a,
   input  logic [BIT_W-1:0] b,
   input  logic             signed_mode,
   input  logic             clr,
   input  logic             en,
   output logic [ACC_W-1:0] acc
);

   localparam int PW = 2 * BIT_W;

   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    b_ext;
   logic [PW-1:0]    prod;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;

   // The low PW bits of a PW x PW product are correct for both signednesses.
   always_comb begin
      a_ext    = signed_mode ? {{BIT_W{a[BIT_W-1]}}, a} : {{BIT_W{1'b0}}, a};
      b_ext    = signed_mode ? {{BIT_W{b[BIT_W-1]}}, b} : {{BIT_W{1'b0}}, b};
      prod     = a_ext * b_ext;
      prod_ext = signed_mode ? {{(ACC_W-PW){prod[PW-1]}}, prod}
                             : {{(ACC_W-PW){1'b0}}, prod};
      acc      = acc_q + prod_ext;
      acc_d    = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/block_matmul_engine.sv
// DIM x DIM matrix multiplier: streams in A/B element pairs, computes C = A x B
// on one MAC (k innermost), then streams C out over a valid/ready handshake.
module block_matmul_engine
   import neurocore_pkg::*;
#(
   parameter int BIT_W = DEF_BIT_W,
   parameter int DIM   = 3,
   parameter int ACC_W = acc_width(BIT_W, DIM)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIT_W-1:0] inp_a,
   input  logic [BIT_W-1:0] inp_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy,
   output logic             done
);

   localparam int NN    = DIM * DIM;
   localparam int IDX_W = $clog2(NN);
   localparam int CNT_W = $clog2(DIM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
   localparam logic [IDX_W-1:0] DIM_IDX  = IDX_W'(DIM);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIM - 1);

   logic [BIT_W-1:0] a_mem [NN];
   logic [BIT_W-1:0] b_mem [NN];
   logic [ACC_W-1:0] c_mem [NN];

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ld_cnt_q, ld_cnt_d;
   logic [IDX_W-1:0] st_cnt_q, st_cnt_d;
   logic [CNT_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic             mode_q, mode_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             ab_we, c_we, mac_en, mac_clr;
   logic [IDX_W-1:0] a_rd_idx, b_rd_idx, c_wr_idx, c_rd_idx, st_nxt;
   logic [ACC_W-1:0] mac_acc;

   assign a_rd_idx = IDX_W'(i_q) * DIM_IDX + IDX_W'(k_q);
   assign b_rd_idx = IDX_W'(k_q) * DIM_IDX + IDX_W'(j_q);
   assign c_wr_idx = IDX_W'(i_q) * DIM_IDX + IDX_W'(j_q);

   mac_unit #(
      .BIT_W (BIT_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk         (clk),
      .rst         (rst),
      .a           (a_mem[a_rd_idx]),
      .b           (b_mem[b_rd_idx]),
      .signed_mode (mode_q),
      .clr         (mac_clr),
      .en          (mac_en),
      .acc         (mac_acc)
   );

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      st_cnt_d    = st_cnt_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      mode_d      = mode_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ab_we       = 1'b0;
      c_we        = 1'b0;
      mac_en      = 1'b0;
      mac_clr     = 1'b0;
      st_nxt      = st_cnt_q + IDX_W'(1);
      // Leaving COMPUTE preloads C[0]; in STORE the next element is staged.
      c_rd_idx    = (state_q == ST_STORE) ? st_nxt : '0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d    = ST_LOAD;
               mode_d     = signed_mode;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         ST_LOAD: begin
            if (in_valid && in_ready_q) begin
               ab_we = 1'b1;
               if (ld_cnt_q == LAST_IDX) begin
                  state_d    = ST_COMPUTE;
                  in_ready_d = 1'b0;
                  ld_cnt_d   = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + IDX_W'(1);
               end
            end
         end
         ST_COMPUTE: begin
            mac_en = 1'b1;
            if (k_q == LAST_CNT) begin
               mac_clr = 1'b1;
               c_we    = 1'b1;
               k_d     = '0;
               if (j_q == LAST_CNT) begin
                  j_d = '0;
                  if (i_q == LAST_CNT) begin
                     i_d         = '0;
                     state_d     = ST_STORE;
                     out_valid_d = 1'b1;
                     out_data_d  = c_mem[c_rd_idx];
                  end else begin
                     i_d = i_q + CNT_W'(1);
                  end
               end else begin
                  j_d = j_q + CNT_W'(1);
               end
            end else begin
               k_d = k_q + CNT_W'(1);
            end
         end
         ST_STORE: begin
            if (out_valid_q && out_ready) begin
               if (st_cnt_q == LAST_IDX) begin
                  state_d     = ST_IDLE;
                  st_cnt_d    = '0;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  st_cnt_d   = st_nxt;
                  out_data_d = c_mem[c_rd_idx];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort && state_q != ST_IDLE) begin
         state_d     = ST_IDLE;
         ld_cnt_d    = '0;
         st_cnt_d    = '0;
         i_d         = '0;
         j_d         = '0;
         k_d         = '0;
         in_ready_d  = 1'b0;
         out_valid_d = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         ab_we       = 1'b0;
         c_we        = 1'b0;
         mac_en      = 1'b0;
         mac_clr     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ld_cnt_q    <= '0;
         st_cnt_q    <= '0;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         st_cnt_q    <= st_cnt_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Buffers keep their contents across reset.
   always_ff @(posedge clk) begin
      if (ab_we) begin
         a_mem[ld_cnt_q] <= inp_a;
         b_mem[ld_cnt_q] <= inp_b;
      end
      if (c_we) begin
         c_mem[c_wr_idx] <= mac_acc;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
